// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: mult/div sequencer
// state encodings, the hard-wired zero register and stall-reason bit slots.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bit positions inside the stall-reason vector
    localparam int STALL_LOAD_USE    = 0;  // load in EX feeds ID
    localparam int STALL_BR_ALU      = 1;  // branch compares an EX ALU result
    localparam int STALL_BR_LOAD     = 2;  // branch compares a load still in EX
    localparam int STALL_BR_MEM_LOAD = 3;  // branch compares a load now in MEM
    localparam int STALL_MD_READ     = 4;  // mfhi/mflo before HI/LO is written
    localparam int STALL_MD_BUSY     = 5;  // second mult/div while unit occupied
    localparam int NUM_STALL         = 6;

    // A pipeline destination hazards the ID instruction only when it is a
    // real register and matches a source the instruction actually reads.
    function automatic logic reg_match(
        input logic [4:0] wr,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (wr != REG_ZERO) && ((wr == rs) || (uses_rt && (wr == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Multi-cycle mult/div sequencer: accepts a start, holds busy for the
// selected latency and pulses the HI/LO write exactly LAT cycles after go.
module hazard_ctrl_md_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic go,
    output logic busy,
    output logic hilo_we,
    output logic active
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_state_t       state_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   load_s;
    logic            accept_s;

    assign load_s   = is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
    assign accept_s = (state_r == MD_IDLE) && start;
    assign active   = (state_r != MD_IDLE);

    // Sequencer state and countdown; BUSY is left as the count reaches zero
    // so that DONE lands exactly LAT cycles after the accepting cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= load_s;
                        state_r <= (load_s == '0) ? MD_DONE : MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_r <= MD_IDLE;
                end
                default: begin
                    state_r <= MD_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Unit handshake outputs, all held quiet while reset is asserted
    always_comb begin
        if (!reset) begin
            go      = 1'b0;
            busy    = 1'b0;
            hilo_we = 1'b0;
        end else begin
            go      = accept_s;
            busy    = accept_s || (state_r != MD_IDLE);
            hilo_we = (state_r == MD_DONE);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core (sits in ID next to the
// forwarding unit). Stalls on load-use and unready branch operands, flushes
// IF/ID on taken branches/jumps and sequences the shared mult/div unit.
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic       ID_Branch,
    input  logic       ID_Jump,
    input  logic       Branch_Taken,
    input  logic       ID_MdStart,
    input  logic       ID_MdDiv,
    input  logic       ID_MdRead,
    input  logic [4:0] IDEX_WR,
    input  logic       IDEX_RegWrite,
    input  logic       IDEX_MemRead,
    input  logic [4:0] EXMEM_WR,
    input  logic       EXMEM_MemRead,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       Md_Go,
    output logic       Md_Busy,
    output logic       Md_HiLoWe
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] Stat_Stalls,
    output logic [CNT_W-1:0] Stat_Flushes,
    output logic [CNT_W-1:0] Stat_MdStalls
`endif
);

    logic                 ex_match_s;
    logic                 mem_match_s;
    logic [NUM_STALL-1:0] reason_s;
    logic                 stall_s;
    logic                 md_active_s;
    logic                 md_start_s;

    assign ex_match_s  = reg_match(IDEX_WR,  IFID_Rs, IFID_Rt, IFID_UsesRt);
    assign mem_match_s = reg_match(EXMEM_WR, IFID_Rs, IFID_Rt, IFID_UsesRt);

    // Collect every reason forwarding cannot cover; a branch on a load
    // stalls here first, then again via the MEM-stage check next cycle.
    always_comb begin
        reason_s                    = '0;
        reason_s[STALL_LOAD_USE]    = IDEX_MemRead && ex_match_s;
        reason_s[STALL_BR_ALU]      = ID_Branch && IDEX_RegWrite && !IDEX_MemRead && ex_match_s;
        reason_s[STALL_BR_LOAD]     = ID_Branch && IDEX_MemRead && ex_match_s;
        reason_s[STALL_BR_MEM_LOAD] = ID_Branch && EXMEM_MemRead && mem_match_s;
        reason_s[STALL_MD_READ]     = ID_MdRead && md_active_s;
        reason_s[STALL_MD_BUSY]     = ID_MdStart && md_active_s;
    end

    assign stall_s    = |reason_s;
    assign md_start_s = ID_MdStart && !stall_s;

    hazard_ctrl_md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start_s),
        .is_div  (ID_MdDiv),
        .go      (Md_Go),
        .busy    (Md_Busy),
        .hilo_we (Md_HiLoWe),
        .active  (md_active_s)
    );

    // Pipeline write-enables, bubble and flush; a stall always beats a flush
    always_comb begin
        if (!reset) begin
            PC_Write    = 1'b1;
            IFID_Write  = 1'b1;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b0;
        end else begin
            PC_Write    = !stall_s;
            IFID_Write  = !stall_s;
            IDEX_Bubble = stall_s;
            IFID_Flush  = !stall_s && (ID_Jump || (ID_Branch && Branch_Taken));
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stat_stalls_r;
    logic [CNT_W-1:0] stat_flushes_r;
    logic [CNT_W-1:0] stat_md_stalls_r;
    logic             md_stall_s;

    assign md_stall_s = reason_s[STALL_MD_READ] || reason_s[STALL_MD_BUSY];

    // Saturating event counters for stall, flush and mult/div stall cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_stalls_r    <= '0;
            stat_flushes_r   <= '0;
            stat_md_stalls_r <= '0;
        end else begin
            if (stall_s && !(&stat_stalls_r)) begin
                stat_stalls_r <= stat_stalls_r + CNT_W'(1);
            end
            if (IFID_Flush && !(&stat_flushes_r)) begin
                stat_flushes_r <= stat_flushes_r + CNT_W'(1);
            end
            if (md_stall_s && !(&stat_md_stalls_r)) begin
                stat_md_stalls_r <= stat_md_stalls_r + CNT_W'(1);
            end
        end
    end

    assign Stat_Stalls   = stat_stalls_r;
    assign Stat_Flushes  = stat_flushes_r;
    assign Stat_MdStalls = stat_md_stalls_r;
`endif

endmodule
